// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D-cache slow-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    CL_I = 1'b0,
    CL_D = 1'b1
  } client_t;

  function automatic client_t other_client(input client_t c);
    return (c == CL_I) ? CL_D : CL_I;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the I-cache and D-cache requesters.
module mem_arb_pick import mem_arb_pkg::*; #(
  parameter int unsigned RR_MODE  = 0,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             req_I,
  input  logic             req_D,
  input  client_t          last,
  input  logic [CNT_W-1:0] wait_cnt,
  input  logic             lock,
  output logic             win_vld,
  output client_t          win
);

  always_comb begin
    win_vld = lock | req_I | req_D;
    win     = CL_I;
    if (lock) begin
      win = CL_D;
    end else if (req_I && req_D) begin
      if (RR_MODE != 0)
        win = other_client(last);
      else
        win = (wait_cnt == CNT_W'(MAX_WAIT)) ? CL_I : CL_D;
    end else if (req_D) begin
      win = CL_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one slow-memory port between I-cache and D-cache, one block transaction at a time.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned ADDR_W   = 28,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned RR_MODE  = 0,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read_I,
  input  logic              mem_write_I,
  input  logic [ADDR_W-1:0] mem_addr_I,
  input  logic [DATA_W-1:0] mem_wdata_I,
  output logic [DATA_W-1:0] mem_rdata_I,
  output logic              mem_ready_I,
  input  logic              mem_read_D,
  input  logic              mem_write_D,
  input  logic [ADDR_W-1:0] mem_addr_D,
  input  logic [DATA_W-1:0] mem_wdata_D,
  output logic [DATA_W-1:0] mem_rdata_D,
  output logic              mem_ready_D,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_t       state, state_nxt;
  client_t          grant, last, win;
  logic [CNT_W-1:0] wait_cnt;
  logic             prev_dwrite;
  logic             req_I, req_D, lock, win_vld, arb;

  assign req_I = mem_read_I | mem_write_I;
  assign req_D = mem_read_D | mem_write_D;
  // A D write-back followed by its refill read must not be split by an I grant.
  assign lock  = (state == RELEASE) && prev_dwrite && mem_read_D;
  assign arb   = (state != BUSY) && win_vld;

  mem_arb_pick #(
    .RR_MODE  (RR_MODE),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_pick (
    .req_I    (req_I),
    .req_D    (req_D),
    .last     (last),
    .wait_cnt (wait_cnt),
    .lock     (lock),
    .win_vld  (win_vld),
    .win      (win)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = RELEASE;
      RELEASE: state_nxt = win_vld ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state       <= IDLE;
      grant       <= CL_I;
      last        <= CL_I;
      wait_cnt    <= '0;
      prev_dwrite <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state <= state_nxt;
      if (arb) begin
        grant <= win;
        if (win == CL_D) begin
          mem_addr  <= mem_addr_D;
          mem_wdata <= mem_wdata_D;
          mem_write <= mem_write_D;
          mem_read  <= mem_read_D & ~mem_write_D;
        end else begin
          mem_addr  <= mem_addr_I;
          mem_wdata <= mem_wdata_I;
          mem_write <= mem_write_I;
          mem_read  <= mem_read_I & ~mem_write_I;
        end
      end else if (state == BUSY && mem_ready) begin
        mem_read    <= 1'b0;
        mem_write   <= 1'b0;
        last        <= grant;
        prev_dwrite <= (grant == CL_D) && mem_write;
      end
      if (RR_MODE == 0) begin
        if (!req_I)
          wait_cnt <= '0;
        else if (arb && win == CL_I)
          wait_cnt <= '0;
        else if (arb && wait_cnt != CNT_W'(MAX_WAIT))
          wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign mem_ready_I = mem_ready && (state == BUSY) && (grant == CL_I);
  assign mem_ready_D = mem_ready && (state == BUSY) && (grant == CL_D);
  assign mem_rdata_I = mem_rdata;
  assign mem_rdata_D = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: fixed-priority (dut0) and round-robin (dut1) instances.
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          proc_reset;
  logic          mem_read_I, mem_write_I, mem_read_D, mem_write_D;
  logic [AW-1:0] mem_addr_I, mem_addr_D;
  logic [DW-1:0] mem_wdata_I, mem_wdata_D;

  logic [DW-1:0] rdata_I [2];
  logic [DW-1:0] rdata_D [2];
  logic          rdy_I   [2];
  logic          rdy_D   [2];
  logic          m_rd    [2];
  logic          m_wr    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] m_rdata [2];
  logic          m_rdy   [2];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_WAIT(4)) dut0 (
    .clk(clk), .proc_reset(proc_reset),
    .mem_read_I(mem_read_I), .mem_write_I(mem_write_I), .mem_addr_I(mem_addr_I),
    .mem_wdata_I(mem_wdata_I), .mem_rdata_I(rdata_I[0]), .mem_ready_I(rdy_I[0]),
    .mem_read_D(mem_read_D), .mem_write_D(mem_write_D), .mem_addr_D(mem_addr_D),
    .mem_wdata_D(mem_wdata_D), .mem_rdata_D(rdata_D[0]), .mem_ready_D(rdy_D[0]),
    .mem_read(m_rd[0]), .mem_write(m_wr[0]), .mem_addr(m_addr[0]),
    .mem_wdata(m_wdata[0]), .mem_rdata(m_rdata[0]), .mem_ready(m_rdy[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_WAIT(4)) dut1 (
    .clk(clk), .proc_reset(proc_reset),
    .mem_read_I(mem_read_I), .mem_write_I(mem_write_I), .mem_addr_I(mem_addr_I),
    .mem_wdata_I(mem_wdata_I), .mem_rdata_I(rdata_I[1]), .mem_ready_I(rdy_I[1]),
    .mem_read_D(mem_read_D), .mem_write_D(mem_write_D), .mem_addr_D(mem_addr_D),
    .mem_wdata_D(mem_wdata_D), .mem_rdata_D(rdata_D[1]), .mem_ready_D(rdy_D[1]),
    .mem_read(m_rd[1]), .mem_write(m_wr[1]), .mem_addr(m_addr[1]),
    .mem_wdata(m_wdata[1]), .mem_rdata(m_rdata[1]), .mem_ready(m_rdy[1])
  );

  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    return {a, 4'h1, ~a, 4'h2, a ^ 28'h5A5A5A5, 4'h3, a, 4'h4};
  endfunction

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    lat      = 2;
  int    sel      = 0;
  string tname    = "init";

  always @(posedge clk) cyc <= cyc + 1;

  // Slow memory model: ready pulse lat cycles after a request is first seen.
  int mcnt [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (proc_reset) begin
        m_rdy[k]   <= 1'b0;
        mcnt[k]    <= 0;
        m_rdata[k] <= '0;
      end else begin
        m_rdy[k] <= 1'b0;
        if ((m_rd[k] | m_wr[k]) && !m_rdy[k]) begin
          if (mcnt[k] >= lat - 1) begin
            m_rdy[k]   <= 1'b1;
            mcnt[k]    <= 0;
            m_rdata[k] <= m_rd[k] ? line_of(m_addr[k]) : '1;
          end else begin
            mcnt[k] <= mcnt[k] + 1;
          end
        end else begin
          mcnt[k] <= 0;
        end
      end
    end
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rd;
    logic          wr;
  } creq_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rd;
    logic          wr;
    int            gap;
  } exp_start_t;

  typedef struct {
    logic          ri;
    logic          rdd;
    logic [DW-1:0] data;
  } exp_rdy_t;

  creq_t      cq_I [$];
  creq_t      cq_D [$];
  exp_start_t exp_s [$];
  exp_rdy_t   exp_r [$];
  int         req_cyc_I = 0, req_cyc_D = 0;
  int         last_start_c = 0, last_rdy_c = 0;
  logic       prev_req [2] = '{1'b0, 1'b0};

  // Cache-side clients: hold the head request until its ready, then move on.
  always @(negedge clk) begin
    if (rdy_I[sel] && cq_I.size() > 0) void'(cq_I.pop_front());
    if (rdy_D[sel] && cq_D.size() > 0) void'(cq_D.pop_front());
    if (cq_I.size() > 0) begin
      if (!(mem_read_I | mem_write_I)) req_cyc_I = cyc;
      mem_addr_I = cq_I[0].addr; mem_wdata_I = cq_I[0].wdata;
      mem_read_I = cq_I[0].rd;   mem_write_I = cq_I[0].wr;
    end else begin
      mem_read_I = 1'b0; mem_write_I = 1'b0;
    end
    if (cq_D.size() > 0) begin
      if (!(mem_read_D | mem_write_D)) req_cyc_D = cyc;
      mem_addr_D = cq_D[0].addr; mem_wdata_D = cq_D[0].wdata;
      mem_read_D = cq_D[0].rd;   mem_write_D = cq_D[0].wr;
    end else begin
      mem_read_D = 1'b0; mem_write_D = 1'b0;
    end
  end

  // Scoreboard: each new memory transaction and each client ready pops one expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (k == sel && (m_rd[k] | m_wr[k]) && !prev_req[k]) begin
        n_checks++;
        if (exp_s.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected_start: got addr=%h rd=%b wr=%b, required none", tname, m_addr[k], m_rd[k], m_wr[k]);
        end else begin
          exp_start_t es;
          es = exp_s.pop_front();
          if (m_addr[k] !== es.addr || m_rd[k] !== es.rd || m_wr[k] !== es.wr ||
              (es.wr && m_wdata[k] !== es.wdata)) begin
            n_fail++;
            $display("FAIL %s start: got addr=%h rd=%b wr=%b wdata=%h, required addr=%h rd=%b wr=%b wdata=%h",
                     tname, m_addr[k], m_rd[k], m_wr[k], m_wdata[k], es.addr, es.rd, es.wr, es.wdata);
          end
          if (es.gap >= 0) begin
            n_checks++;
            if (cyc - last_rdy_c != es.gap) begin
              n_fail++;
              $display("FAIL %s gap: got %0d cycles after ready, required %0d", tname, cyc - last_rdy_c, es.gap);
            end
          end
        end
        last_start_c = cyc;
      end
      if (k == sel && (rdy_I[k] | rdy_D[k])) begin
        n_checks++;
        if (exp_r.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected_ready: got rdyI=%b rdyD=%b, required none", tname, rdy_I[k], rdy_D[k]);
        end else begin
          exp_rdy_t er;
          er = exp_r.pop_front();
          if (rdy_I[k] !== er.ri || rdy_D[k] !== er.rdd ||
              rdata_I[k] !== er.data || rdata_D[k] !== er.data) begin
            n_fail++;
            $display("FAIL %s ready: got rdyI=%b rdyD=%b rdataI=%h rdataD=%h, required rdyI=%b rdyD=%b rdata=%h",
                     tname, rdy_I[k], rdy_D[k], rdata_I[k], rdata_D[k], er.ri, er.rdd, er.data);
          end
        end
        last_rdy_c = cyc;
      end
      prev_req[k] = m_rd[k] | m_wr[k];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpush(input bit is_d, input logic [AW-1:0] a, input logic [DW-1:0] w,
                       input logic rd, input logic wr);
    creq_t c;
    c = '{addr: a, wdata: w, rd: rd, wr: wr};
    if (is_d) cq_D.push_back(c); else cq_I.push_back(c);
  endtask

  task automatic exp_push(input bit is_d, input logic [AW-1:0] a, input logic [DW-1:0] w,
                          input logic rd, input logic wr, input int gap);
    logic eff_rd;
    eff_rd = rd & ~wr;
    exp_s.push_back('{a, w, eff_rd, wr, gap});
    exp_r.push_back('{!is_d, is_d, eff_rd ? line_of(a) : '1});
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      ok = (exp_s.size() == 0 && exp_r.size() == 0);
    end
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    cq_I.delete(); cq_D.delete(); exp_s.delete(); exp_r.delete();
    step(2);
    proc_reset = 1'b0;
    step(1);
    last_rdy_c = cyc;
  endtask

  task automatic test_reset();
    tname = "reset"; sel = 0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({m_rd[k], m_wr[k]} !== 2'b00) begin
        n_fail++; $display("FAIL reset_req%0d: got %b, required 00", k, {m_rd[k], m_wr[k]});
      end
      n_checks++;
      if (m_addr[k] !== '0 || m_wdata[k] !== '0) begin
        n_fail++; $display("FAIL reset_addr%0d: got addr=%h wdata=%h, required 0", k, m_addr[k], m_wdata[k]);
      end
      n_checks++;
      if ({rdy_I[k], rdy_D[k]} !== 2'b00) begin
        n_fail++; $display("FAIL reset_ready%0d: got %b, required 00", k, {rdy_I[k], rdy_D[k]});
      end
    end
  endtask

  task automatic test_single_read();
    bit ok;
    tname = "single"; sel = 0; lat = 5;
    do_reset();
    cpush(0, 28'h0000010, '0, 1'b1, 1'b0);
    exp_push(0, 28'h0000010, '0, 1'b1, 1'b0, -1);
    wait_drain(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: %0d starts/%0d readies left, required 0", exp_s.size(), exp_r.size()); end
    n_checks++;
    if (last_start_c != req_cyc_I + 1) begin
      n_fail++; $display("FAIL single_req_latency: got %0d, required 1", last_start_c - req_cyc_I);
    end
    n_checks++;
    if (last_rdy_c != last_start_c + 5) begin
      n_fail++; $display("FAIL single_ready_latency: got %0d, required 5", last_rdy_c - last_start_c);
    end
    step(6);
  endtask

  task automatic test_simultaneous();
    bit ok;
    tname = "simultaneous"; sel = 0; lat = 3;
    do_reset();
    cpush(0, 28'h0000020, '0, 1'b1, 1'b0);
    cpush(1, 28'h0000030, '0, 1'b1, 1'b0);
    exp_push(1, 28'h0000030, '0, 1'b1, 1'b0, -1);
    exp_push(0, 28'h0000020, '0, 1'b1, 1'b0, 2);
    wait_drain(80, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL simultaneous_timeout: %0d starts/%0d readies left, required 0", exp_s.size(), exp_r.size()); end
    step(4);
  endtask

  task automatic test_lock(input int s);
    bit ok;
    logic [DW-1:0] w;
    tname = (s == 0) ? "lock_fixed" : "lock_rr"; sel = s; lat = 2;
    do_reset();
    w = {4{32'hDEAD_0123}};
    cpush(1, 28'h0000123, w, 1'b0, 1'b1);
    cpush(1, 28'h0000456, '0, 1'b1, 1'b0);
    cpush(0, 28'h0000789, '0, 1'b1, 1'b0);
    exp_push(1, 28'h0000123, w, 1'b0, 1'b1, -1);
    exp_push(1, 28'h0000456, '0, 1'b1, 1'b0, 2);
    exp_push(0, 28'h0000789, '0, 1'b1, 1'b0, 2);
    wait_drain(80, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: %0d starts/%0d readies left, required 0", tname, exp_s.size(), exp_r.size()); end
    step(4);
  endtask

  task automatic test_starvation();
    bit ok;
    tname = "starvation"; sel = 0; lat = 2;
    do_reset();
    for (int i = 0; i < 6; i++) cpush(1, 28'h0000200 + AW'(i), '0, 1'b1, 1'b0);
    cpush(0, 28'h0000100, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) exp_push(1, 28'h0000200 + AW'(i), '0, 1'b1, 1'b0, (i == 0) ? -1 : 2);
    exp_push(0, 28'h0000100, '0, 1'b1, 1'b0, 2);
    for (int i = 4; i < 6; i++) exp_push(1, 28'h0000200 + AW'(i), '0, 1'b1, 1'b0, 2);
    wait_drain(150, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL starvation_timeout: %0d starts/%0d readies left, required 0", exp_s.size(), exp_r.size()); end
    n_checks++;
    if (dut0.wait_cnt !== 3'd0) begin
      n_fail++; $display("FAIL starvation_wait_cnt: got %0d, required 0", dut0.wait_cnt);
    end
    step(4);
  endtask

  task automatic test_round_robin();
    bit ok;
    tname = "round_robin"; sel = 1; lat = 2;
    do_reset();
    for (int i = 0; i < 3; i++) cpush(0, 28'h0000300 + AW'(i), '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_push(0, 28'h0000300 + AW'(i), '0, 1'b1, 1'b0, (i == 0) ? -1 : 2);
      exp_push(1, 28'h0000400 + AW'(i), '0, 1'b1, 1'b0, 2);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1);
      ok = (exp_s.size() <= 5);
    end
    for (int i = 0; i < 3; i++) cpush(1, 28'h0000400 + AW'(i), '0, 1'b1, 1'b0);
    wait_drain(120, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL round_robin_timeout: %0d starts/%0d readies left, required 0", exp_s.size(), exp_r.size()); end
    step(4);
  endtask

  task automatic test_read_write_same();
    bit ok;
    logic [DW-1:0] w;
    tname = "rw_same"; sel = 0; lat = 2;
    do_reset();
    w = {4{32'h0BAD_F00D}};
    cpush(1, 28'h00000AB, w, 1'b1, 1'b1);
    cpush(1, 28'h00000AB, '0, 1'b1, 1'b0);
    exp_push(1, 28'h00000AB, w, 1'b1, 1'b1, -1);
    exp_push(1, 28'h00000AB, '0, 1'b1, 1'b0, 2);
    wait_drain(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rw_same_timeout: %0d starts/%0d readies left, required 0", exp_s.size(), exp_r.size()); end
    step(4);
  endtask

  task automatic test_reset_busy();
    bit ok;
    tname = "reset_busy"; sel = 0; lat = 8;
    do_reset();
    cpush(0, 28'h0000055, '0, 1'b1, 1'b0);
    exp_s.push_back('{28'h0000055, '0, 1'b1, 1'b0, -1});
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1);
      ok = (exp_s.size() == 0);
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_busy_start: request not issued, required start"); end
    step(1);
    proc_reset = 1'b1;
    cq_I.delete();
    step(1);
    proc_reset = 1'b0;
    n_checks++;
    if ({m_rd[0], m_wr[0]} !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy_req: got %b, required 00", {m_rd[0], m_wr[0]});
    end
    step(12);
    cpush(1, 28'h0000066, '0, 1'b1, 1'b0);
    exp_push(1, 28'h0000066, '0, 1'b1, 1'b0, -1);
    wait_drain(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_busy_timeout: %0d starts/%0d readies left, required 0", exp_s.size(), exp_r.size()); end
    n_checks++;
    if (last_start_c != req_cyc_D + 1) begin
      n_fail++; $display("FAIL reset_busy_latency: got %0d, required 1", last_start_c - req_cyc_D);
    end
    step(4);
  endtask

  initial begin
    proc_reset  = 1'b1;
    mem_read_I  = 1'b0; mem_write_I = 1'b0; mem_addr_I = '0; mem_wdata_I = '0;
    mem_read_D  = 1'b0; mem_write_D = 1'b0; mem_addr_D = '0; mem_wdata_D = '0;
    step(2);
    test_reset();
    test_single_read();
    test_simultaneous();
    test_lock(0);
    test_lock(1);
    test_starvation();
    test_round_robin();
    test_read_write_same();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
